// File: rtl/vend_change_dispenser_if.sv
// Vend request/response bundle between the vending machine controller (master)
// and the change dispenser (slave).
interface vend_change_dispenser_if;
    logic       req;
    logic [1:0] item_in;
    logic [3:0] change_in;
    logic       ready;
    logic       item_drop;
    logic [1:0] item_out;
    logic       coin_valid;
    logic [3:0] coin_val;
    logic [3:0] remaining;
    logic       done;

    modport master (
        output req, item_in, change_in,
        input  ready, item_drop, item_out, coin_valid, coin_val, remaining, done
    );

    modport slave (
        input  req, item_in, change_in,
        output ready, item_drop, item_out, coin_valid, coin_val, remaining, done
    );
endinterface

// File: rtl/vend_change_dispenser.sv
// Vending change dispenser: drops the requested item, then pays change greedily in 4/2/1 coins.
// Optional macro VEND_COIN_GAP_EN inserts one idle GAP cycle between consecutive coins.
module vend_change_dispenser (
    input  logic                          clk,
    input  logic                          rst,
    vend_change_dispenser_if.slave        bus
);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] DROP = 3'd1;
    localparam logic [2:0] PAY  = 3'd2;
    localparam logic [2:0] GAP  = 3'd3;
    localparam logic [2:0] DONE = 3'd4;

    logic [2:0] state, state_nxt;
    logic [1:0] item_r;
    logic [3:0] rem_r;
    logic [3:0] coin;
    logic [3:0] rem_after;

    // Largest coin not exceeding what is still owed; zero when nothing is owed.
    always_comb begin
        coin = 4'd0;
        if (rem_r[3:2] != 2'b00)  coin = 4'd4;
        else if (rem_r[1])        coin = 4'd2;
        else if (rem_r[0])        coin = 4'd1;
    end

    assign rem_after = rem_r - coin;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (bus.req) begin
                    if (bus.item_in != 2'd0)        state_nxt = DROP;
                    else if (bus.change_in != 4'd0) state_nxt = PAY;
                    else                            state_nxt = DONE;
                end
            end
            DROP: state_nxt = (rem_r != 4'd0) ? PAY : DONE;
            PAY: begin
                if (rem_after == 4'd0) state_nxt = DONE;
                else begin
`ifdef VEND_COIN_GAP_EN
                    state_nxt = GAP;
`else
                    state_nxt = PAY;
`endif
                end
            end
            GAP:     state_nxt = PAY;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            item_r <= 2'd0;
            rem_r  <= 4'd0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (bus.req) begin
                        item_r <= bus.item_in;
                        rem_r  <= bus.change_in;
                    end
                end
                PAY:     rem_r  <= rem_after;
                DONE:    item_r <= 2'd0;
                default: ;
            endcase
        end
    end

    // Outputs decode straight from state so reset clears them asynchronously.
    assign bus.ready      = (state == IDLE);
    assign bus.item_drop  = (state == DROP);
    assign bus.item_out   = (state == DROP) ? item_r : 2'd0;
    assign bus.coin_valid = (state == PAY);
    assign bus.coin_val   = (state == PAY) ? coin : 4'd0;
    assign bus.remaining  = rem_r;
    assign bus.done       = (state == DONE);

endmodule

// File: tb/tb_vend_change_dispenser.sv
// Directed + randomized bench: per-transaction expected trace built from the change-making rules.
module tb_vend_change_dispenser;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    vend_change_dispenser_if bus();

    vend_change_dispenser dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int rdy;
        int drop;
        int item;
        int cv;
        int cval;
        int rem;
        int dn;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string ph, input exp_t e);
        chk({ph, ".ready"},      {31'd0, bus.ready},      e.rdy);
        chk({ph, ".item_drop"},  {31'd0, bus.item_drop},  e.drop);
        chk({ph, ".item_out"},   {30'd0, bus.item_out},   e.item);
        chk({ph, ".coin_valid"}, {31'd0, bus.coin_valid}, e.cv);
        chk({ph, ".coin_val"},   {28'd0, bus.coin_val},   e.cval);
        chk({ph, ".remaining"},  {28'd0, bus.remaining},  e.rem);
        chk({ph, ".done"},       {31'd0, bus.done},       e.dn);
    endtask

    // Expected cycle-by-cycle outputs from the cycle after acceptance through the next IDLE cycle.
    function automatic void build(input int item, input int change);
        int rem;
        int coin;
        exp_q.delete();
        rem = change;
        if (item != 0) exp_q.push_back('{0, 1, item, 0, 0, rem, 0});
        while (rem > 0) begin
            coin = (rem >= 4) ? 4 : ((rem >= 2) ? 2 : 1);
            exp_q.push_back('{0, 0, 0, 1, coin, rem, 0});
            rem -= coin;
`ifdef VEND_COIN_GAP_EN
            if (rem > 0) exp_q.push_back('{0, 0, 0, 0, 0, rem, 0});
`endif
        end
        exp_q.push_back('{0, 0, 0, 0, 0, 0, 1});
        exp_q.push_back('{1, 0, 0, 0, 0, 0, 0});
    endfunction

    // Called at a negedge of an IDLE cycle; returns at the negedge of the following IDLE cycle.
    task automatic txn(input int item, input int change, input bit hold);
        string ph;
        chk($sformatf("pre_i%0d_c%0d.ready", item, change), {31'd0, bus.ready}, 1);
        bus.req       = 1'b1;
        bus.item_in   = item[1:0];
        bus.change_in = change[3:0];
        build(item, change);
        @(posedge clk);
        for (int i = 0; i < exp_q.size(); i++) begin
            @(negedge clk);
            if (hold) begin
                bus.req       = 1'b1;
                bus.item_in   = 2'($urandom_range(0, 3));
                bus.change_in = 4'($urandom_range(0, 15));
            end else begin
                bus.req = 1'b0;
            end
            ph = $sformatf("i%0d_c%0d_k+%0d", item, change, i + 1);
            chk_out(ph, exp_q[i]);
        end
    endtask

    initial begin
        exp_t zero_idle;
        zero_idle = '{1, 0, 0, 0, 0, 0, 0};
        rst           = 1'b1;
        bus.req       = 1'b0;
        bus.item_in   = 2'd0;
        bus.change_in = 4'd0;

        // Reset state, with a request pending that must not be taken.
        #2;
        bus.req = 1'b1; bus.item_in = 2'd3; bus.change_in = 4'd9;
        #1;
        chk_out("reset", zero_idle);
        @(posedge clk);
        @(negedge clk);
        chk_out("reset_edge", zero_idle);
        rst     = 1'b0;
        bus.req = 1'b0;

        // Accepted at the first rising edge after reset release.
        txn(2, 7, 1'b0);
        txn(1, 0, 1'b0);
        txn(0, 15, 1'b0);
        txn(0, 0, 1'b0);
        txn(3, 6, 1'b0);

        // req held high with changing values while busy: only the IDLE-edge values are taken.
        txn(2, 5, 1'b1);
        txn(1, 15, 1'b1);
        txn(3, 3, 1'b0);

        for (int n = 0; n < 20; n++) begin
            txn(int'($urandom_range(0, 3)), int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
        end
        bus.req = 1'b0;
        @(negedge clk);
        chk_out("idle_after_random", zero_idle);

        // Reset mid-PAY with change 15: abort at once, no done pulse.
        bus.req = 1'b1; bus.item_in = 2'd0; bus.change_in = 4'd15;
        @(posedge clk);
        @(negedge clk);
        bus.req = 1'b0;
        chk({"midpay.coin_valid"}, {31'd0, bus.coin_valid}, 1);
        @(negedge clk);
        chk({"midpay.remaining"}, {28'd0, bus.remaining}, 11);
        rst = 1'b1;
        #1;
        chk_out("async_reset", zero_idle);
        @(posedge clk);
        #1;
        chk_out("reset_hold", zero_idle);
        @(negedge clk);
        chk_out("reset_hold2", zero_idle);
        rst = 1'b0;
        txn(2, 7, 1'b0);
        txn(0, 1, 1'b0);
        bus.req = 1'b0;
        @(negedge clk);
        chk_out("final_idle", zero_idle);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/vend_change_dispenser.md
VEND_CHANGE_DISPENSER -- requirements
Module: vend_change_dispenser

Interface
REQ-001 SHALL have port: clk  input  1  system clock, all state updates on rising edge.
REQ-002 SHALL have port: rst  input  1  reset; one clock; reset is asynchronous and active-high.
REQ-003 SHALL have port: req  input  1  vend request from vending machine, valid with item_in/change_in.
REQ-004 SHALL have port: item_in  input  2  item number to release; 0 = refund only, no item.
REQ-005 SHALL have port: change_in  input  4  change owed, unsigned units 0..15.
REQ-006 SHALL have port: ready  output  1  high only in IDLE; request accepted when req & ready at clock edge.
REQ-007 SHALL have port: item_drop  output  1  one-cycle pulse releasing item_out.
REQ-008 SHALL have port: item_out  output  2  latched item number, valid while item_drop high, else 0.
REQ-009 SHALL have port: coin_valid  output  1  one-cycle pulse per coin paid.
REQ-010 SHALL have port: coin_val  output  4  coin value (4, 2 or 1) while coin_valid high, else 0.
REQ-011 SHALL have port: remaining  output  4  change still to pay.
REQ-012 SHALL have port: done  output  1  one-cycle pulse at end of each transaction.

Function
REQ-013 SHALL implement FSM states IDLE, DROP, PAY, GAP, DONE.
REQ-014 SHALL, in IDLE on req & ready at edge k, latch item_in and change_in into internal registers; remaining = change_in.
REQ-015 SHALL go IDLE->DROP if item_in != 0; IDLE->PAY if item_in == 0 and change_in != 0; IDLE->DONE if both zero.
REQ-016 SHALL, in DROP (cycle k+1), assert item_drop = 1 with item_out = latched item, then go PAY if remaining != 0, else DONE.
REQ-017 SHALL, each PAY cycle, pay greedily the largest of {4,2,1} <= remaining: coin_valid = 1, coin_val = that coin, remaining decremented by it at the edge ending the cycle.
REQ-018 SHALL leave PAY when the post-payment remaining is 0, going to DONE; otherwise stay in PAY (or GAP, see REQ-026).
REQ-019 SHALL, in DONE, assert done = 1 for exactly one cycle, then return to IDLE.
REQ-020 SHALL ignore req whenever ready = 0; no queuing, inputs not sampled.
REQ-021 SHALL never underflow remaining; sum of coin_val over a transaction SHALL equal the latched change_in.
REQ-022 SHALL bound transaction length: max 5 coins (15 = 4+4+4+2+1), max 7 cycles from accept to done without gap.

Reset
REQ-023 SHALL, while rst = 1, asynchronously force state IDLE and ready = 1, with item_drop, item_out, coin_valid, coin_val, remaining, done = 0.
REQ-024 SHALL, on rst mid-transaction, abort immediately; latched item/change discarded, no done pulse.
REQ-025 SHALL accept a request at the first rising edge after rst deasserts.

Configuration
REQ-026 SHALL, with macro VEND_COIN_GAP_EN defined, pass through GAP for one cycle (coin_valid = 0, remaining held) between consecutive coins; the final coin goes directly to DONE.
REQ-027 SHALL, without VEND_COIN_GAP_EN, omit GAP entirely so that consecutive PAY cycles pay back-to-back coins.

Verification
REQ-028 SHALL verify reset: rst=1 mid-PAY with change 15 -> all outputs 0 and ready=1 the same cycle; no done pulse.
REQ-029 SHALL verify item=2, change=7 accepted at k -> item_drop/item_out=2 at k+1; coins 4,2,1 at k+2..k+4; done at k+5; ready at k+6.
REQ-030 SHALL verify item=1, change=0 -> item_drop at k+1; done at k+2; coin_valid never asserted.
REQ-031 SHALL verify item=0, change=15 -> no item_drop; coins 4,4,4,2,1 at k+1..k+5; remaining 11,7,3,1,0; done at k+6.
REQ-032 SHALL verify req held high with new values through a transaction -> ignored until ready; next accept at the first IDLE edge.
REQ-033 SHALL verify with VEND_COIN_GAP_EN, item=3, change=6 -> drop at k+1; coin 4 at k+2; gap at k+3; coin 2 at k+4; done at k+5.
